// File: rtl/sram_fifo_pkg.sv
// Shared sizes and types for the 256x36 SRAM-backed FIFO controller.
package sram_fifo_pkg;
    localparam int DEPTH  = 256;
    localparam int WIDTH  = 36;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 9;

    typedef logic [WIDTH-1:0]  data_t;
    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry capture/skid buffer holding SRAM read data until the consumer takes it.
module sram_fifo_obuf
    import sram_fifo_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push_i,
    input  data_t      push_data_i,
    input  logic       pop_i,
    output logic       valid_o,
    output data_t      head_o,
    output logic [1:0] count_o
);
    data_t      mem_q [2];
    logic       head_q;
    logic [1:0] cnt_q;
    logic       tail;
    logic       pop;

    assign valid_o = (cnt_q != 2'd0);
    assign pop     = pop_i && valid_o;
    assign head_o  = mem_q[head_q];
    assign count_o = cnt_q;
    // With cnt_q==2 a push can only coincide with a pop, so the freed head slot becomes the tail.
    assign tail    = head_q ^ cnt_q[0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (pop) head_q <= ~head_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) mem_q[tail] <= push_data_i;
    end
endmodule

// File: rtl/sram_fifo_ctrl_256x36.sv
// FIFO controller sharing one 1RW SRAM port between enqueue writes and prefetch reads.
// Optional SRAM_FIFO_BYPASS_EN: when the FIFO is otherwise empty, enqueues go straight to the output buffer.
module sram_fifo_ctrl_256x36
    import sram_fifo_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [WIDTH-1:0]  enq_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [WIDTH-1:0]  deq_data,
    output logic [CNT_W-1:0]  occupancy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [WIDTH-1:0]  sram_wdata,
    input  logic [WIDTH-1:0]  sram_rdata
);
    ptr_t       wr_ptr_q, rd_ptr_q;
    cnt_t       sram_cnt_q, sram_cnt_d;
    logic       rd_inflight_q;
    ptr_t       addr_q;
    logic       wmode_q;
    data_t      wdata_q;
    logic [1:0] ob_cnt;
    logic       rd_sel, wr_sel, byp_ok, byp_sel, enq_fire;
    logic       ob_push;
    data_t      ob_push_data;

    // Arbitration looks only at registered state so deq_ready never reaches the SRAM pins.
    assign rd_sel = (sram_cnt_q != '0) && ((3'(ob_cnt) + 3'(rd_inflight_q)) < 3'd2);

`ifdef SRAM_FIFO_BYPASS_EN
    assign byp_ok = (sram_cnt_q == '0) && !rd_inflight_q && (ob_cnt != 2'd2);
`else
    assign byp_ok = 1'b0;
`endif

    assign enq_ready = reset_n && !rd_sel && ((sram_cnt_q < cnt_t'(DEPTH)) || byp_ok);
    assign enq_fire  = enq_valid && enq_ready;
    assign byp_sel   = enq_fire && byp_ok;
    assign wr_sel    = enq_fire && !byp_ok;

    always_comb begin
        sram_en    = rd_sel || wr_sel;
        sram_addr  = addr_q;
        sram_wmode = wmode_q;
        sram_wdata = wdata_q;
        if (rd_sel) begin
            sram_addr  = rd_ptr_q;
            sram_wmode = 1'b0;
        end else if (wr_sel) begin
            sram_addr  = wr_ptr_q;
            sram_wmode = 1'b1;
            sram_wdata = enq_data;
        end
    end

    assign sram_cnt_d = sram_cnt_q + cnt_t'(wr_sel) - cnt_t'(rd_sel);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            sram_cnt_q    <= '0;
            rd_inflight_q <= 1'b0;
            addr_q        <= '0;
            wmode_q       <= 1'b0;
            wdata_q       <= '0;
        end else begin
            if (wr_sel) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            if (rd_sel) rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            sram_cnt_q    <= sram_cnt_d;
            rd_inflight_q <= rd_sel;
            addr_q        <= sram_addr;
            wmode_q       <= sram_wmode;
            wdata_q       <= sram_wdata;
        end
    end

    // Read data is only looked at in the cycle after a read, so an undriven bus never enters the buffer.
    assign ob_push      = rd_inflight_q || byp_sel;
    assign ob_push_data = rd_inflight_q ? sram_rdata : enq_data;

    sram_fifo_obuf u_obuf (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_i      (ob_push),
        .push_data_i (ob_push_data),
        .pop_i       (deq_ready),
        .valid_o     (deq_valid),
        .head_o      (deq_data),
        .count_o     (ob_cnt)
    );

    assign occupancy = sram_cnt_q + cnt_t'(rd_inflight_q) + cnt_t'(ob_cnt);
endmodule
